rotate_ctrl: RTL and testbench

Sequencing controller that sits directly upstream of the 8-bit barrel shifter and drives its data, direction and shift-amount inputs. It holds a loaded 8-bit pattern and steps the shift amount on a prescaled tick, either free-running or one step per request. The result is a rotating (or, optionally, bouncing) pattern on the shifter output, for the board LED chaser.

---
 rtl/rotate_pkg.sv | 9 +
 rtl/rotate_ctrl_tick_prescaler.sv | 28 ++
 rtl/rotate_ctrl.sv | 115 +++++++++++
 tb/tb_rotate_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/rotate_pkg.sv
// Shared widths and state encodings for the LED-chaser rotate controller.
package rotate_pkg;
  localparam int DATA_W = 8;
  localparam int SHA_W  = 3;
  localparam logic [SHA_W-1:0] SHA_MAX = '1;

  typedef enum logic {IDLE, RUN} state_e;
  typedef enum logic {UP, DOWN}  phase_e;
endpackage

// File: rtl/rotate_ctrl_tick_prescaler.sv
// Free-running divider: tick on the last count of each TICK_DIV-cycle window while enabled.
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = en && (cnt_q == LAST);
    if (clr)       cnt_d = '0;
    else if (tick) cnt_d = '0;
    else if (en)   cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/rotate_ctrl.sv
// Steps the barrel-shifter amount on a prescaled tick or manual step.
// Ping-pong sequencing is built only when ROTATE_CTRL_BOUNCE_EN is defined.
module rotate_ctrl
  import rotate_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] pattern_in,
  input  logic              dir_in,
  input  logic              run,
  input  logic              step,
  input  logic              bounce_in,
  output logic [DATA_W-1:0] sh_in,
  output logic              sh_lr,
  output logic [SHA_W-1:0]  sh_sha,
  output logic              busy,
  output logic              wrap
);
  state_e            state_q, state_d;
  phase_e            phase_q, phase_d;
  logic [DATA_W-1:0] pat_q, pat_d;
  logic              lr_q, lr_d;
  logic [SHA_W-1:0]  sha_q, sha_d;
  logic              wrap_q, wrap_d;
  logic              tick, adv, bounce_sel;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state_q == RUN),
    .clr  ((state_q == IDLE) || load),
    .tick (tick)
  );

`ifdef ROTATE_CTRL_BOUNCE_EN
  assign bounce_sel = bounce_in;
`else
  logic unused_bounce;
  assign unused_bounce = bounce_in;
  assign bounce_sel    = 1'b0;
`endif

  // A step pulse coinciding with run is swallowed by the IDLE->RUN transition.
  assign adv = tick || ((state_q == IDLE) && step && !run);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    pat_d   = pat_q;
    lr_d    = lr_q;
    sha_d   = sha_q;
    wrap_d  = 1'b0;
    case (state_q)
      IDLE:    if (run)  state_d = RUN;
      RUN:     if (!run) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (load) begin
      pat_d   = pattern_in;
      lr_d    = dir_in;
      sha_d   = '0;
      phase_d = UP;
    end else if (adv) begin
      if (bounce_sel && phase_q == UP) begin
        if (sha_q == SHA_MAX) begin
          phase_d = DOWN;
          sha_d   = SHA_MAX - 1'b1;
          wrap_d  = 1'b1;
        end else begin
          sha_d = sha_q + 1'b1;
        end
      end else if (bounce_sel) begin
        if (sha_q == '0) begin
          phase_d = UP;
          sha_d   = SHA_W'(1);
          wrap_d  = 1'b1;
        end else begin
          sha_d = sha_q - 1'b1;
        end
      end else begin
        // Plain modulo stepping; leaving bounce mid-DOWN resumes counting up.
        phase_d = UP;
        sha_d   = sha_q + 1'b1;
        wrap_d  = (sha_q == SHA_MAX);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      phase_q <= UP;
      pat_q   <= '0;
      lr_q    <= 1'b0;
      sha_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      pat_q   <= pat_d;
      lr_q    <= lr_d;
      sha_q   <= sha_d;
      wrap_q  <= wrap_d;
    end
  end

  assign sh_in  = pat_q;
  assign sh_lr  = lr_q;
  assign sh_sha = sha_q;
  assign busy   = (state_q == RUN);
  assign wrap   = wrap_q;
endmodule

// File: tb/tb_rotate_ctrl.sv
// Directed bench for rotate_ctrl: one instance at TICK_DIV=4, one at TICK_DIV=1.
module tb_rotate_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0, dir_in = 1'b0, step = 1'b0, bounce_in = 1'b0;
  logic       run4 = 1'b0, run1 = 1'b0;
  logic [7:0] pattern_in = 8'h00;

  logic [7:0] a_in, b_in;
  logic       a_lr, b_lr, a_busy, b_busy, a_wrap, b_wrap;
  logic [2:0] a_sha, b_sha;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rotate_ctrl #(.TICK_DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .load(load), .pattern_in(pattern_in), .dir_in(dir_in),
    .run(run4), .step(step), .bounce_in(bounce_in),
    .sh_in(a_in), .sh_lr(a_lr), .sh_sha(a_sha), .busy(a_busy), .wrap(a_wrap)
  );

  rotate_ctrl #(.TICK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .load(load), .pattern_in(pattern_in), .dir_in(dir_in),
    .run(run1), .step(step), .bounce_in(bounce_in),
    .sh_in(b_in), .sh_lr(b_lr), .sh_sha(b_sha), .busy(b_busy), .wrap(b_wrap)
  );

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    cyc(2);
    n_chk++;
    if ({a_in, a_lr, a_sha, a_busy, a_wrap} !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_state: got in=%h lr=%b sha=%0d busy=%b wrap=%b, want all 0",
               a_in, a_lr, a_sha, a_busy, a_wrap);
    end
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic test_load();
    load = 1'b1; pattern_in = 8'h81; dir_in = 1'b1;
    cyc(1);
    load = 1'b0;
    n_chk++;
    if (a_in !== 8'h81 || a_lr !== 1'b1 || a_sha !== 3'd0 || a_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL load_idle: got in=%h lr=%b sha=%0d busy=%b, want 81 1 0 0",
               a_in, a_lr, a_sha, a_busy);
    end
  endtask

  task automatic test_run_steps();
    run4 = 1'b1;
    cyc(1);
    n_chk++;
    if (a_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL run_busy: got %b want 1", a_busy);
    end
    for (int k = 1; k <= 8; k++) begin
      cyc(3);
      n_chk++;
      if (a_sha !== 3'((k - 1) % 8) || a_wrap !== 1'b0) begin
        n_fail++;
        $display("FAIL run_hold_%0d: got sha=%0d wrap=%b want sha=%0d wrap=0",
                 k, a_sha, a_wrap, (k - 1) % 8);
      end
      cyc(1);
      n_chk++;
      if (a_sha !== 3'(k % 8) || a_wrap !== (k == 8)) begin
        n_fail++;
        $display("FAIL run_step_%0d: got sha=%0d wrap=%b want sha=%0d wrap=%b",
                 k, a_sha, a_wrap, k % 8, (k == 8));
      end
    end
    cyc(1);
    n_chk++;
    if (a_wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_one_cycle: got %b want 0", a_wrap);
    end
    run4 = 1'b0;
    cyc(1);
    n_chk++;
    if (a_busy !== 1'b0 || a_sha !== 3'd0) begin
      n_fail++;
      $display("FAIL run_stop: got busy=%b sha=%0d want 0 0", a_busy, a_sha);
    end
  endtask

  task automatic test_step_and_load_in_run();
    for (int i = 0; i < 3; i++) begin
      step = 1'b1;
      cyc(1);
      step = 1'b0;
      cyc(1);
    end
    n_chk++;
    if (a_sha !== 3'd3) begin
      n_fail++;
      $display("FAIL manual_steps: got sha=%0d want 3", a_sha);
    end
    step = 1'b1; run4 = 1'b1;
    cyc(1);
    step = 1'b0;
    n_chk++;
    if (a_busy !== 1'b1 || a_sha !== 3'd3) begin
      n_fail++;
      $display("FAIL step_with_run: got busy=%b sha=%0d want 1 3", a_busy, a_sha);
    end
    cyc(8);
    n_chk++;
    if (a_sha !== 3'd5) begin
      n_fail++;
      $display("FAIL run_to_5: got sha=%0d want 5", a_sha);
    end
    cyc(3);
    load = 1'b1; pattern_in = 8'h0F; dir_in = 1'b0;
    cyc(1);
    load = 1'b0;
    n_chk++;
    if (a_in !== 8'h0F || a_lr !== 1'b0 || a_sha !== 3'd0 || a_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL load_in_tick: got in=%h lr=%b sha=%0d busy=%b want 0f 0 0 1",
               a_in, a_lr, a_sha, a_busy);
    end
    cyc(3);
    n_chk++;
    if (a_sha !== 3'd0) begin
      n_fail++;
      $display("FAIL post_load_hold: got sha=%0d want 0", a_sha);
    end
    cyc(1);
    n_chk++;
    if (a_sha !== 3'd1) begin
      n_fail++;
      $display("FAIL post_load_step: got sha=%0d want 1", a_sha);
    end
  endtask

  task automatic test_async_reset();
    cyc(12);
    n_chk++;
    if (a_sha !== 3'd4 || a_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset: got sha=%0d busy=%b want 4 1", a_sha, a_busy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({a_in, a_lr, a_sha, a_busy, a_wrap} !== 14'h0) begin
      n_fail++;
      $display("FAIL async_reset: got in=%h lr=%b sha=%0d busy=%b wrap=%b want all 0",
               a_in, a_lr, a_sha, a_busy, a_wrap);
    end
    run4 = 1'b0;
    #3 rst_n = 1'b1;
    cyc(3);
    n_chk++;
    if (a_busy !== 1'b0 || a_sha !== 3'd0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got busy=%b sha=%0d want 0 0", a_busy, a_sha);
    end
  endtask

  task automatic test_bounce();
    logic [2:0] exp_sha [1:15];
    logic       exp_wrap [1:15];
`ifdef ROTATE_CTRL_BOUNCE_EN
    exp_sha  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6,
                 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1};
    exp_wrap = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1};
`else
    exp_sha  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0,
                 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    exp_wrap = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
`endif
    bounce_in = 1'b1;
    load = 1'b1; pattern_in = 8'h3C; dir_in = 1'b1;
    cyc(1);
    load = 1'b0;
    run1 = 1'b1;
    cyc(1);
    n_chk++;
    if (b_busy !== 1'b1 || b_sha !== 3'd0 || b_in !== 8'h3C) begin
      n_fail++;
      $display("FAIL bounce_start: got busy=%b sha=%0d in=%h want 1 0 3c", b_busy, b_sha, b_in);
    end
    for (int i = 1; i <= 15; i++) begin
      cyc(1);
      n_chk++;
      if (b_sha !== exp_sha[i] || b_wrap !== exp_wrap[i]) begin
        n_fail++;
        $display("FAIL bounce_seq_%0d: got sha=%0d wrap=%b want sha=%0d wrap=%b",
                 i, b_sha, b_wrap, exp_sha[i], exp_wrap[i]);
      end
    end
    run1 = 1'b0;
    bounce_in = 1'b0;
    cyc(1);
  endtask

  initial begin
    test_reset();
    test_load();
    test_run_steps();
    test_step_and_load_in_run();
    test_async_reset();
    test_bounce();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
